// File: rtl/decoder38_scan.sv
// ---------------------------------------------------------------------------
// decoder38_scan
//
// Registered 3-to-8 decoder with a dwell timer. Two ways of driving a line:
//   - load mode (iMode = 0): a 3-bit code is accepted over iValid/oReady and
//     its one-hot line is held for HOLD_CYCLES clock cycles, then released.
//   - scan mode (iMode = 1): lines 0..7 are stepped in order, each held for
//     HOLD_CYCLES cycles, wrapping 7 -> 0 with no gap between lines.
// Typical use: digit/anode select for multiplexed displays, one-hot strobes.
//
// Parameters:
//   HOLD_CYCLES  dwell per asserted line in clk cycles (0 behaves as 1)
//   CNT_W        dwell counter width, 2**CNT_W must exceed HOLD_CYCLES
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   iEn      in   block enable; low aborts any activity on the next edge
//   iMode    in   0 = load, 1 = scan
//   iValid   in   iData carries a code (load mode)
//   iData    in   [2:0] code to decode
//   oReady   out  a code can be accepted this cycle
//   oData    out  [7:0] registered one-hot line (one-cold when inverted)
//   oValid   out  oData currently drives a line
//   oCode    out  [2:0] code currently driven, 0 when idle
//
// Build option:
//   DECODER38_ACTIVE_LOW_EN  when defined, oData is inverted (one-cold) so
//                            active-low anodes can be driven directly; idle
//                            and reset value becomes 8'hFF.
// ---------------------------------------------------------------------------
module decoder38_scan #(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       iEn,
   input  logic       iMode,
   input  logic       iValid,
   input  logic [2:0] iData,
   output logic       oReady,
   output logic [7:0] oData,
   output logic       oValid,
   output logic [2:0] oCode
);

   // A zero dwell would never show a line, so it is stretched to one cycle.
   localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_EFF - 1);

`ifdef DECODER38_ACTIVE_LOW_EN
   localparam logic [7:0] DATA_IDLE = 8'hFF;
`else
   localparam logic [7:0] DATA_IDLE = 8'h00;
`endif

   // Output polarity is folded in before the flop so oData stays glitch free.
   function automatic logic [7:0] line_of(input logic [2:0] code);
      logic [7:0] one_hot;
      one_hot = 8'h01 << code;
`ifdef DECODER38_ACTIVE_LOW_EN
      return ~one_hot;
`else
      return one_hot;
`endif
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_SCAN
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [2:0]       code_q,  code_d;
   logic [7:0]       data_q,  data_d;
   logic             valid_q, valid_d;
   logic             go_idle;

   // Next-state logic. The counter holds the number of edges still to pass
   // before the current line ends; zero means this is the last cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      data_d  = data_q;
      valid_d = valid_q;
      go_idle = 1'b0;

      case (state_q)
         ST_IDLE: begin
            go_idle = 1'b1;
            // Scan takes precedence: iValid is ignored once scan is requested.
            if (iEn && iMode) begin
               go_idle = 1'b0;
               state_d = ST_SCAN;
               cnt_d   = RELOAD;
               code_d  = 3'd0;
               data_d  = line_of(3'd0);
               valid_d = 1'b1;
            end else if (iEn && iValid) begin
               go_idle = 1'b0;
               state_d = ST_HOLD;
               cnt_d   = RELOAD;
               code_d  = iData;
               data_d  = line_of(iData);
               valid_d = 1'b1;
            end
         end

         ST_HOLD: begin
            if (!iEn || (cnt_q == '0)) begin
               go_idle = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_SCAN: begin
            // A mode change is only honoured at a dwell boundary so the
            // current line always finishes; disable aborts immediately.
            if (!iEn) begin
               go_idle = 1'b1;
            end else if (cnt_q == '0) begin
               if (iMode) begin
                  cnt_d  = RELOAD;
                  code_d = code_q + 3'd1;
                  data_d = line_of(code_q + 3'd1);
               end else begin
                  go_idle = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         default: begin
            go_idle = 1'b1;
         end
      endcase

      if (go_idle) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         code_d  = 3'd0;
         data_d  = DATA_IDLE;
         valid_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         code_q  <= 3'd0;
         data_q  <= DATA_IDLE;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   // Ready depends only on registered state and the enable, never on iValid.
   assign oReady = (state_q == ST_IDLE) && iEn;
   assign oData  = data_q;
   assign oValid = valid_q;
   assign oCode  = code_q;

endmodule

// File: doc/decoder38_scan.md
Name: decoder38_scan

Overview:
Registered 3-to-8 decoder with timing control, the decode-side counterpart of the 8-3 encoder. It operates in one of two modes:
- Load mode: accepts a 3-bit code over a valid/ready handshake and drives the one-hot line for a fixed dwell time.
- Scan mode: steps through all eight lines, 0 to 7, holding each one for the dwell time.

Used for digit/anode select in multiplexed displays and for one-hot strobe generation.

Parameters:
HOLD_CYCLES, 4, dwell length in clk cycles per asserted line; legal range 1..65535; a value of 0 is treated as 1.
CNT_W, 16, width of the dwell counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
iEn  input  1  block enable; low aborts any activity.
iMode  input  1  0 = load mode, 1 = scan mode.
iValid  input  1  iData holds a code to decode (load mode only).
iData  input  3  binary code 0..7.
oReady  output  1  block can accept a code this cycle.
oData  output  8  registered one-hot decode of the current code.
oValid  output  1  oData currently holds an asserted line.
oCode  output  3  code currently driven; 0 when idle.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n low, asynchronous; released synchronously by the integrator):
  - state = IDLE, oData = 8'h00, oValid = 0, oReady = 1, oCode = 0, dwell counter = 0.
- States: IDLE, HOLD, SCAN.
- oReady = 1 only in IDLE with iEn = 1. It is registered-state based, with no combinational path from iValid.
- IDLE:
  - iEn = 1, iMode = 0, iValid = 1 at edge k: the code is accepted.
    - From edge k: oData = 1 << iData, oCode = iData, oValid = 1.
    - Counter = HOLD_CYCLES - 1; state goes to HOLD.
    - Latency from accept to output is 1 registered edge.
  - iEn = 1, iMode = 1: state goes to SCAN.
    - oCode = 0, oData = 8'h01, oValid = 1, counter = HOLD_CYCLES - 1.
    - iValid is ignored.
  - Otherwise: stay in IDLE with outputs cleared.
- HOLD:
  - oReady = 0; iValid and iData are ignored; counter decrements each edge.
  - When the counter reaches 0, the next edge clears oData/oValid/oCode and returns to IDLE.
  - oValid is therefore high for exactly HOLD_CYCLES cycles.
  - Back-to-back loads leave 1 idle cycle between dwells.
- SCAN:
  - The counter decrements each edge.
  - At 0 with iMode = 1: oCode increments modulo 8 (7 wraps to 0), oData shifts to the new one-hot value, and the counter reloads.
    - oValid stays high continuously; there is no gap between lines.
  - At 0 with iMode = 0: clear the outputs and return to IDLE. A mode change takes effect only at a dwell boundary, so the current line always completes.
- Abort: iEn = 0 in HOLD or SCAN causes the next edge to clear all outputs and enter IDLE, regardless of the counter. iEn low has priority over every other input.
- oData is always either all-zero or exactly one bit set. A glitch-free transition is guaranteed because all outputs come from flops.
- Reset asserted mid-HOLD or mid-SCAN returns the block to the reset values immediately.

Optional Feature:
DECODER38_ACTIVE_LOW_EN
- Defined: oData is inverted (one-cold), for driving active-low anodes directly.
  - Reset and idle value is 8'hFF; code 3 drives 8'hF7.
  - oValid, oReady and oCode are unchanged.
- Undefined: oData is active-high as described above, with reset and idle value 8'h00.

Test Plan:
1. Load, HOLD_CYCLES = 4: iData = 3'd5 with iValid = 1 for one cycle.
   - Required: next edge oData = 8'h20, oCode = 5, oValid high for exactly 4 cycles, oReady low for those 4 cycles, then oData = 8'h00 and oReady = 1.
2. Back-to-back loads: hold iValid = 1, present 3'd0 and then 3'd7 as each is accepted.
   - Required: 8'h01 for 4 cycles, 1 idle cycle, then 8'h80 for 4 cycles.
   - Exactly two accepts occur (iValid & oReady).
3. Scan with wrap, HOLD_CYCLES = 2: iMode = 1 for 20 cycles.
   - Required: oData sequence 01, 02, 04, 08, 10, 20, 40, 80, 01, … with 2 cycles per value and oValid continuously high.
4. Mode exit: drop iMode to 0 one cycle into the dwell on 8'h04.
   - Required: 8'h04 completes its full dwell, then outputs clear and the block returns to IDLE.
5. Abort and reset: iEn = 0 mid-HOLD on code 6.
   - Required: oData = 8'h00 on the next edge.
   - Then pulse rst_n low mid-SCAN: all outputs are at reset values before the next clk edge.
6. With DECODER38_ACTIVE_LOW_EN defined: load code 3.
   - Required: oData = 8'hF7 during the dwell and 8'hFF when idle and after reset.
